// File: rtl/riscv_hwloop_pkg.sv
// Shared types and codes for the RI5CY hardware-loop register file.
// Optional read port enabled by RISCV_HWLP_READ_EN (see riscv_hwloop_regfile).
package riscv_hwloop_pkg;

   typedef enum logic [1:0] {
      HWLP_IDLE = 2'd0,
      HWLP_RUN  = 2'd1,
      HWLP_LAST = 2'd2
   } hwlp_state_e;

   localparam int HWLP_WE_START = 0;
   localparam int HWLP_WE_END   = 1;
   localparam int HWLP_WE_CNT   = 2;

   localparam logic [1:0] HWLP_RD_START = 2'd0;
   localparam logic [1:0] HWLP_RD_END   = 2'd1;
   localparam logic [1:0] HWLP_RD_CNT   = 2'd2;

   // Loop state is a pure function of the counter value it will hold.
   function automatic hwlp_state_e hwlp_state_of(input logic is_zero, input logic is_one);
      if (is_zero)
         return HWLP_IDLE;
      else if (is_one)
         return HWLP_LAST;
      else
         return HWLP_RUN;
   endfunction

endpackage

// File: rtl/riscv_hwloop_cnt.sv
// One hardware-loop iteration counter with its IDLE/RUN/LAST state.
// Priority: flush > counter write > decrement; decrementing an idle loop saturates at 0.
module riscv_hwloop_cnt
   import riscv_hwloop_pkg::*;
#(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 we,
   input  logic [CNT_WIDTH-1:0] wdata,
   input  logic                 dec,
   input  logic                 flush,
   output logic [CNT_WIDTH-1:0] counter,
   output logic                 active,
   output logic                 last,
   output logic                 dec_err
);

   logic [CNT_WIDTH-1:0] cnt_reg;
   logic [CNT_WIDTH-1:0] cnt_next;
   hwlp_state_e          state_reg;
   hwlp_state_e          state_next;
   logic                 cnt_zero;

   assign cnt_zero = (cnt_reg == '0);

   always_comb begin
      cnt_next = cnt_reg;
      if (flush)
         cnt_next = '0;
      else if (we)
         cnt_next = wdata;
      else if (dec && !cnt_zero)
         cnt_next = cnt_reg - CNT_WIDTH'(1);
      state_next = hwlp_state_of(cnt_next == '0, cnt_next == CNT_WIDTH'(1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg   <= '0;
         state_reg <= HWLP_IDLE;
      end else begin
         cnt_reg   <= cnt_next;
         state_reg <= state_next;
      end
   end

   // Only a decrement that would actually have been applied counts as illegal.
   assign dec_err = dec && !we && !flush && cnt_zero;
   assign counter = cnt_reg;
   assign active  = (state_reg != HWLP_IDLE);
   assign last    = (state_reg == HWLP_LAST);

endmodule

// File: rtl/riscv_hwloop_regfile.sv
// Parametrised hardware-loop register file: start/end addresses, counters, state, sticky error.
// Define RISCV_HWLP_READ_EN to add a registered debug/CSR read port.
module riscv_hwloop_regfile
   import riscv_hwloop_pkg::*;
#(
   parameter int N_REGS     = 2,
   parameter int N_REG_BITS = (N_REGS > 2) ? $clog2(N_REGS) : 1,
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] hwlp_start_data_i,
   input  logic [ADDR_WIDTH-1:0] hwlp_end_data_i,
   input  logic [CNT_WIDTH-1:0]  hwlp_cnt_data_i,
   input  logic [2:0]            hwlp_we_i,
   input  logic [N_REG_BITS-1:0] hwlp_regid_i,
   input  logic                  valid_i,
   input  logic [N_REGS-1:0]     hwlp_dec_cnt_i,
   input  logic                  flush_i,
`ifdef RISCV_HWLP_READ_EN
   input  logic [N_REG_BITS-1:0] hwlp_rd_regid_i,
   input  logic [1:0]            hwlp_rd_sel_i,
   output logic [31:0]           hwlp_rd_data_o,
`endif
   output logic [ADDR_WIDTH-1:0] hwlp_start_addr_o [N_REGS],
   output logic [ADDR_WIDTH-1:0] hwlp_end_addr_o   [N_REGS],
   output logic [CNT_WIDTH-1:0]  hwlp_counter_o    [N_REGS],
   output logic [N_REGS-1:0]     hwlp_active_o,
   output logic [N_REGS-1:0]     hwlp_last_o,
   output logic                  hwlp_err_o
);

   logic              wr_ok;
   logic              wr_err;
   logic [N_REGS-1:0] dec_req;
   logic [N_REGS-1:0] dec_grant;
   logic              dec_multi;
   logic [N_REGS-1:0] dec_err;
   logic              err_reg;

   assign wr_ok  = (32'(hwlp_regid_i) < N_REGS);
   assign wr_err = (|hwlp_we_i) && !wr_ok;

   // Keep only the lowest requesting loop; extra requests are flagged.
   assign dec_req   = valid_i ? hwlp_dec_cnt_i : '0;
   assign dec_grant = dec_req & (~dec_req + N_REGS'(1));
   assign dec_multi = |(dec_req & (dec_req - N_REGS'(1)));

   genvar gi;
   generate
      for (gi = 0; gi < N_REGS; gi++) begin : g_loop
         logic                  sel;
         logic [ADDR_WIDTH-1:0] start_addr;
         logic [ADDR_WIDTH-1:0] end_addr;

         assign sel = wr_ok && (hwlp_regid_i == N_REG_BITS'(gi));

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               start_addr <= '0;
               end_addr   <= '0;
            end else begin
               if (sel && hwlp_we_i[HWLP_WE_START])
                  start_addr <= hwlp_start_data_i;
               if (sel && hwlp_we_i[HWLP_WE_END])
                  end_addr <= hwlp_end_data_i;
            end
         end

         assign hwlp_start_addr_o[gi] = start_addr;
         assign hwlp_end_addr_o[gi]   = end_addr;

         riscv_hwloop_cnt #(
            .CNT_WIDTH (CNT_WIDTH)
         ) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .we      (sel && hwlp_we_i[HWLP_WE_CNT]),
            .wdata   (hwlp_cnt_data_i),
            .dec     (dec_grant[gi]),
            .flush   (flush_i),
            .counter (hwlp_counter_o[gi]),
            .active  (hwlp_active_o[gi]),
            .last    (hwlp_last_o[gi]),
            .dec_err (dec_err[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_reg <= 1'b0;
      else if (wr_err || dec_multi || (|dec_err))
         err_reg <= 1'b1;
   end

   assign hwlp_err_o = err_reg;

`ifdef RISCV_HWLP_READ_EN
   logic        rd_ok;
   logic [31:0] rd_data_reg;

   assign rd_ok = (32'(hwlp_rd_regid_i) < N_REGS);

   // Reads sample the current registers, so a colliding write is not yet visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_reg <= '0;
      end else if (!rd_ok) begin
         rd_data_reg <= '0;
      end else begin
         case (hwlp_rd_sel_i)
            HWLP_RD_START: rd_data_reg <= 32'(hwlp_start_addr_o[hwlp_rd_regid_i]);
            HWLP_RD_END:   rd_data_reg <= 32'(hwlp_end_addr_o[hwlp_rd_regid_i]);
            HWLP_RD_CNT:   rd_data_reg <= 32'(hwlp_counter_o[hwlp_rd_regid_i]);
            default:       rd_data_reg <= '0;
         endcase
      end
   end

   assign hwlp_rd_data_o = rd_data_reg;
`endif

endmodule
